pixel_frame_sequencer: RTL and testbench

Parametrised frame controller for the pixel sensor array. It generates the erase/expose/convert/per-row read strobes and a digital ADC ramp code, with exposure programmable per frame. It captures each row's column bus and streams the pixels out as a valid/ready word stream with frame and line markers. It supports single-shot and continuous frame modes, and replaces the fixed four-read, fixed-count FSM in the pixel top level.

---
 rtl/pixel_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the pixel sensor array: sequences erase/expose/convert/read
// strobes and the ADC ramp, then streams each captured row out as valid/ready words.
module pixel_frame_sequencer #(
  parameter int ROWS    = 4,
  parameter int COLS    = 2,
  parameter int DATA_W  = 8,
  parameter int C_ERASE = 5,
  parameter int C_READ  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [CNT_W-1:0]       exposure,
  output logic                   erase,
  output logic                   expose,
  output logic                   convert,
  output logic [DATA_W-1:0]      ramp_code,
  output logic [ROWS-1:0]        read,
  input  logic [COLS*DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   busy
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(C_ERASE - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(C_READ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_SHIFT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  exp_last;
  logic [CNT_W-1:0]  exp_cnt_last;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_nxt;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_nxt;
  logic [DATA_W-1:0] row_buf [COLS];

  // Exposure is held as the index of its last cycle; a request of 0 runs as 1 cycle.
  assign exp_cnt_last = (exposure == '0) ? '0 : exposure - 1'b1;
  assign row_nxt      = row + 1'b1;
  assign col_nxt      = col + 1'b1;

  // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      exp_last  <= '0;
      row       <= '0;
      col       <= '0;
      erase     <= 1'b0;
      expose    <= 1'b0;
      convert   <= 1'b0;
      ramp_code <= '0;
      read      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || continuous) begin
            state    <= S_ERASE;
            exp_last <= exp_cnt_last;
            cnt      <= '0;
            erase    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ERASE: begin
          if (cnt == ERASE_LAST) begin
            state  <= S_EXPOSE;
            cnt    <= '0;
            erase  <= 1'b0;
            expose <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXPOSE: begin
          if (cnt == exp_last) begin
            state   <= S_CONVERT;
            cnt     <= '0;
            expose  <= 1'b0;
            convert <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CONVERT: begin
          // The ramp itself times the convert phase: it ends when the code reaches full scale.
          if (ramp_code == '1) begin
            state     <= S_READ;
            convert   <= 1'b0;
            ramp_code <= '0;
            row       <= '0;
            read      <= ROWS'(1);
          end else begin
            ramp_code <= ramp_code + 1'b1;
          end
        end
        S_READ: begin
          if (cnt == READ_LAST) begin
            state     <= S_SHIFT;
            cnt       <= '0;
            read      <= '0;
            col       <= '0;
            out_valid <= 1'b1;
            out_data  <= pix_data[DATA_W-1:0];
            out_sof   <= (row == '0);
            out_eol   <= (COLS == 1);
            out_eof   <= (COLS == 1) && (row == ROW_LAST);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (out_ready) begin
            if (col != COL_LAST) begin
              col      <= col_nxt;
              out_data <= row_buf[col_nxt];
              out_sof  <= 1'b0;
              out_eol  <= (col_nxt == COL_LAST);
              out_eof  <= (col_nxt == COL_LAST) && (row == ROW_LAST);
            end else begin
              col       <= '0;
              out_valid <= 1'b0;
              out_sof   <= 1'b0;
              out_eol   <= 1'b0;
              out_eof   <= 1'b0;
              if (row != ROW_LAST) begin
                row   <= row_nxt;
                state <= S_READ;
                read  <= ROWS'(1) << row_nxt;
              end else begin
                row <= '0;
                if (continuous) begin
                  state    <= S_ERASE;
                  exp_last <= exp_cnt_last;
                  erase    <= 1'b1;
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the row buffer carries no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (state == S_READ && cnt == READ_LAST) begin
      for (int c = 0; c < COLS; c++) begin
        row_buf[c] <= pix_data[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Self-checking bench for pixel_frame_sequencer: vector table, hand sequences for
// continuous/reset corners, randomized frames against a raster-order frame model.
module tb_pixel_frame_sequencer;

  localparam int ROWS    = 4;
  localparam int COLS    = 2;
  localparam int DATA_W  = 8;
  localparam int C_ERASE = 5;
  localparam int C_READ  = 5;
  localparam int CNT_W   = 16;
  localparam int NWORDS  = ROWS * COLS;
  localparam int PW      = COLS * DATA_W;

  logic              clk = 1'b0;
  logic              reset, start, continuous, out_ready;
  logic [CNT_W-1:0]  exposure;
  logic              erase, expose, convert, out_valid, out_sof, out_eol, out_eof, busy;
  logic [DATA_W-1:0] ramp_code, out_data;
  logic [ROWS-1:0]   read;
  logic [PW-1:0]     pix_data;

  logic              s_start, s_erase, s_expose, s_convert, s_read;
  logic              s_out_valid, s_out_sof, s_out_eol, s_out_eof, s_busy;
  logic [3:0]        s_ramp, s_out_data, s_pix;

  always #5 clk = ~clk;

  pixel_frame_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .C_ERASE(C_ERASE), .C_READ(C_READ), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .exposure(exposure),
    .erase(erase), .expose(expose), .convert(convert), .ramp_code(ramp_code), .read(read),
    .pix_data(pix_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  pixel_frame_sequencer #(
    .ROWS(1), .COLS(1), .DATA_W(4), .C_ERASE(C_ERASE), .C_READ(C_READ), .CNT_W(CNT_W)
  ) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .continuous(1'b0), .exposure(16'd3),
    .erase(s_erase), .expose(s_expose), .convert(s_convert), .ramp_code(s_ramp), .read(s_read),
    .pix_data(s_pix), .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_sof(s_out_sof), .out_eol(s_out_eol), .out_eof(s_out_eof), .busy(s_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame model inputs and observed frame statistics.
  logic [DATA_W-1:0] pix_tab [ROWS][COLS];
  logic [CNT_W-1:0]  mid_exposure;
  logic              mid_cont, mid_start;
  int n_erase, n_expose, n_convert, ramp_bad, stall_bad, read_bad, gap_bad, busy_bad;
  int wait_cyc, frame_len;
  logic frame_done;
  logic [DATA_W+2:0] got_q [$];

  // Expected word i of a frame: pixels in raster order, markers by position.
  function automatic logic [DATA_W+2:0] model_word(input int i);
    int r = i / COLS;
    int c = i % COLS;
    return {i == NWORDS - 1, c == COLS - 1, i == 0, pix_tab[r][c]};
  endfunction

  // Called at a negedge; watches one frame from its first erase to its eof handshake.
  task automatic observe_frame(input int ready_mode);
    int   cyc = 0;
    logic started = 1'b0;
    logic held = 1'b0;
    logic rdy;
    logic [DATA_W+2:0] held_w = '0;
    logic [DATA_W+2:0] cur_w;
    n_erase = 0; n_expose = 0; n_convert = 0; ramp_bad = 0; stall_bad = 0;
    read_bad = 0; gap_bad = 0; busy_bad = 0; wait_cyc = 0; frame_len = 0;
    frame_done = 1'b0;
    got_q.delete();
    while (!frame_done && cyc < 3000) begin
      if (!started) begin
        if (erase) started = 1'b1;
        else wait_cyc++;
      end
      if (started) begin
        frame_len++;
        if (!busy) busy_bad++;
        if (!(erase || expose || convert || (|read) || out_valid)) gap_bad++;
      end
      if (erase) n_erase++;
      if (expose) n_expose++;
      if (convert) begin
        if (ramp_code != DATA_W'(n_convert)) ramp_bad++;
        n_convert++;
      end else if (ramp_code != '0) begin
        ramp_bad++;
      end
      if (convert && n_convert == 2) begin
        exposure   = mid_exposure;
        continuous = mid_cont;
        start      = mid_start;
      end else if (convert && n_convert == 3) begin
        start = 1'b0;
      end
      if (!$onehot0(read) || ((|read) && out_valid)) read_bad++;
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      pix_data  = PW'($urandom);
      for (int r = 0; r < ROWS; r++) begin
        if (read[r]) begin
          for (int c = 0; c < COLS; c++) pix_data[c*DATA_W +: DATA_W] = pix_tab[r][c];
        end
      end
      cur_w = {out_eof, out_eol, out_sof, out_data};
      if (held && (!out_valid || cur_w != held_w)) stall_bad++;
      held   = out_valid && !rdy;
      held_w = cur_w;
      if (out_valid && rdy) begin
        got_q.push_back(cur_w);
        if (out_eof) frame_done = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic verify_frame(input int exp_expose, input int exp_len);
    check("frame_done", frame_done, 1);
    check("erase_start_wait", wait_cyc, 0);
    check("erase_cycles", n_erase, C_ERASE);
    check("expose_cycles", n_expose, exp_expose);
    check("convert_cycles", n_convert, 2 ** DATA_W);
    check("ramp_errors", ramp_bad, 0);
    check("stall_changes", stall_bad, 0);
    check("read_errors", read_bad, 0);
    check("phase_gaps", gap_bad + busy_bad, 0);
    if (exp_len >= 0) check("frame_len", frame_len, exp_len);
    check("word_count", got_q.size(), NWORDS);
    for (int i = 0; i < NWORDS && i < got_q.size(); i++) check("word", got_q[i], model_word(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pattern_pixels();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pix_tab[r][c] = DATA_W'(2 * r + c);
  endtask

  task automatic random_pixels();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pix_tab[r][c] = DATA_W'($urandom);
  endtask

  typedef struct {
    logic [CNT_W-1:0] exposure;
    int               ready_mode;
    int               exp_expose;
    int               exp_len;
  } vec_t;

  vec_t vecs [5];
  int   extra, k, e, sc, sconv, sramp_bad, swords;
  logic [6:0] sw;

  initial begin
    vecs[0] = '{16'd10, 0, 10, 299};
    vecs[1] = '{16'd0,  0, 1,  290};
    vecs[2] = '{16'd1,  0, 1,  290};
    vecs[3] = '{16'd10, 1, 10, -1};
    vecs[4] = '{16'd33, 0, 33, 322};

    reset = 1'b1; start = 1'b0; continuous = 1'b0; exposure = '0;
    out_ready = 1'b1; pix_data = '0; s_start = 1'b0; s_pix = '0;
    mid_exposure = '0; mid_cont = 1'b0; mid_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_erase", erase, 0);
    check("rst_expose", expose, 0);
    check("rst_convert", convert, 0);
    check("rst_read", read, 0);
    check("rst_ramp", ramp_code, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_markers", {out_sof, out_eol, out_eof}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single frames.
    for (int v = 0; v < 5; v++) begin
      pattern_pixels();
      exposure = vecs[v].exposure;
      mid_exposure = vecs[v].exposure; mid_cont = 1'b0; mid_start = 1'b0;
      pulse_start();
      observe_frame(vecs[v].ready_mode);
      verify_frame(vecs[v].exp_expose, vecs[v].exp_len);
      check("busy_after_single", busy, 0);
      repeat (2) @(negedge clk);
    end

    // Continuous: exposure changes mid-frame 1, continuous drops during frame 2.
    random_pixels();
    exposure = 16'd10; mid_exposure = 16'd20; mid_cont = 1'b1; mid_start = 1'b0;
    continuous = 1'b1;
    @(negedge clk);
    observe_frame(0);
    verify_frame(10, 299);
    check("erase_after_eof", erase, 1);
    mid_exposure = 16'd20; mid_cont = 1'b0;
    observe_frame(0);
    verify_frame(20, 309);
    check("busy_after_cont", busy, 0);
    repeat (5) @(negedge clk);
    check("stays_idle", busy, 0);

    // Start pulse during CONVERT is ignored.
    pattern_pixels();
    exposure = '0; mid_exposure = '0; mid_cont = 1'b0; mid_start = 1'b1;
    pulse_start();
    observe_frame(0);
    verify_frame(1, 290);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (erase || busy) extra++;
      @(negedge clk);
    end
    check("no_second_frame", extra, 0);

    // Reset during EXPOSE, then a clean frame.
    mid_start = 1'b0; exposure = 16'd50; mid_exposure = 16'd50;
    pulse_start();
    k = 0;
    while (!expose && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reached_expose", expose, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mid_outputs",
          {erase, expose, convert, read, ramp_code, out_valid, out_data, out_sof, out_eol, out_eof, busy}, 0);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy || out_valid || erase) extra++;
      @(negedge clk);
    end
    check("idle_after_reset", extra, 0);
    pattern_pixels();
    exposure = 16'd10; mid_exposure = 16'd10;
    pulse_start();
    observe_frame(0);
    verify_frame(10, 299);

    // Randomized frames with random backpressure.
    for (int n = 0; n < 5; n++) begin
      random_pixels();
      e = $urandom_range(0, 20);
      exposure = CNT_W'(e); mid_exposure = CNT_W'(e); mid_cont = 1'b0; mid_start = 1'b0;
      pulse_start();
      observe_frame(2);
      verify_frame((e == 0) ? 1 : e, -1);
      check("busy_after_random", busy, 0);
      @(negedge clk);
    end

    // One-row, one-column, 4-bit instance.
    sc = 0; sconv = 0; sramp_bad = 0; swords = 0; sw = '0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (swords == 0 && sc < 500) begin
      if (s_convert) begin
        if (s_ramp != 4'(sconv)) sramp_bad++;
        sconv++;
      end
      s_pix = s_read ? 4'hA : 4'h5;
      if (s_out_valid) begin
        swords++;
        sw = {s_out_eof, s_out_eol, s_out_sof, s_out_data};
      end
      sc++;
      @(negedge clk);
    end
    check("small_convert_cycles", sconv, 16);
    check("small_ramp_errors", sramp_bad, 0);
    check("small_words", swords, 1);
    check("small_word", sw, 7'b111_1010);
    check("small_busy_after", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
